switch_pkt_checker: RTL and testbench
=====================================

# switch_pkt_checker

Parametrised in-line packet header checker for the N-port switch. It snoops one switch port's byte stream and decodes each packet's target, source and length bytes. It classifies the packet as single, multicast or broadcast, flags every header rule violation and framing error, and keeps saturating per-type statistics. It generalises the 4-port, software-only packet validation to any port count from 2 to 8, in synthesizable RTL that sits beside each switch port.

## Interface
- NUM_PORTS, 4, number of switch ports (2..8); bit i of target/source selects port i
- MAX_LEN, 16, largest legal payload length in bytes (1..255)
- CNT_W, 16, width of each statistics counter
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- valid_in  in  1  byte on data_in is valid
- suspend_in  in  1  downstream stall; a beat is accepted only when valid_in=1 and suspend_in=0
- data_in  in  8  packet byte
- pkt_done  out  1  one-cycle pulse: result outputs valid
- pkt_type  out  2  0 SINGLE, 1 MULTICAST, 2 BROADCAST, 3 INVALID (target==0)
- err_source  out  1  source not one-hot, or a bit at or above NUM_PORTS is set
- err_target  out  1  target==0, or a bit at or above NUM_PORTS is set
- err_overlap  out  1  non-broadcast packet with (source & target)!=0
- err_len  out  1  length field > MAX_LEN
- err_frame  out  1  valid_in dropped mid-packet while suspend_in=0
- single_cnt, multi_cnt, bcast_cnt, err_cnt  out  CNT_W  statistics

## Operation
- Packet format: byte0 target, byte1 source, byte2 length L, then L payload bytes.
- FSM states:
  - IDLE: accepted beat → capture target → SRC.
  - SRC: accepted beat → capture source → LEN.
  - LEN: accepted beat → capture L. L==0 → REPORT; else load down-counter with L → PAYLOAD.
  - PAYLOAD: decrement on each accepted beat; the beat that brings the count to 0 → REPORT.
  - REPORT: one cycle, drives pkt_done → IDLE. A beat arriving while in REPORT is not accepted.
- Stalls: a cycle with suspend_in=1 is a stall. State is held and no beat is accepted.
- Framing error: in SRC, LEN or PAYLOAD, a cycle with valid_in=0 and suspend_in=0 sets err_frame → REPORT.
  - Checks on fields not yet captured are suppressed.
  - pkt_type reflects the target if it was captured.
- err_len packets still consume all L payload bytes; L is at most 255.
- Classification: target with all NUM_PORTS low bits set → BROADCAST; popcount 1 → SINGLE; popcount ≥2 → MULTICAST.
  - BROADCAST is exempt from err_overlap.
- Statistics:
  - Error-free packets increment the counter for their type.
  - Any packet with at least one error flag increments err_cnt only.
  - All counters saturate at all-ones.
- Result outputs hold their value until the next pkt_done.

## Timing
- Reset values: state IDLE, pkt_done=0, pkt_type=0, all err_* =0, all counters=0.
- Reset mid-packet aborts the packet silently: no pkt_done, and the counters clear.
- pkt_done asserts in the cycle after the final accepted beat, or after the framing-error cycle.
- Counters update on the same edge that raises pkt_done.
- Minimum back-to-back spacing is L+4 cycles per packet, because REPORT costs one cycle.

## Configuration
- SWITCH_PKT_CHK_STATS_EN defined: the four statistics counters are implemented as above.
- Undefined: counters are absent, and single_cnt/multi_cnt/bcast_cnt/err_cnt are tied to 0. Ports stay present.

## Structure
- Shared package switch_pkt_pkg holds:
  - the ptype_e enum (SINGLE, MULTICAST, BROADCAST, INVALID);
  - the FSM state enum;
  - a popcount function;
  - the MAX_PORTS=8 constant.
- One combinational sub-module, switch_pkt_classify: it takes target, source and NUM_PORTS, and produces pkt_type, err_source, err_target and err_overlap.

## Test plan
- NUM_PORTS=4, bytes 04,01,02,AA,BB → pkt_done 1 cycle after BB, pkt_type=SINGLE, no errors, single_cnt=1.
- Broadcast 0F,02,00 → pkt_done the cycle after the length byte, BROADCAST, no err_overlap, bcast_cnt=1.
- Bad headers:
  - 06,02,01,55 → MULTICAST, err_overlap=1, err_cnt=1, multi_cnt unchanged.
  - 10,03,00 → err_target=1, err_source=1.
- Length 20 (>16) with 20 payload bytes → err_len=1; pkt_done 1 cycle after byte 20, not earlier.
- Framing: suspend_in=1 for 3 cycles mid-payload → no error and latency +3. valid_in=0 with suspend_in=0 after the source byte → err_frame=1, pkt_done next cycle.
- Assert reset mid-payload → no pkt_done, counters=0. Following packet 08,01,00 → SINGLE; err_cnt saturation checked with CNT_W=2.

Source files
------------

// File: rtl/switch_pkt_pkg.sv
// Shared types and helpers for the switch packet header checker.
package switch_pkt_pkg;

  localparam int MAX_PORTS = 8;

  typedef enum logic [1:0] {
    SINGLE    = 2'd0,
    MULTICAST = 2'd1,
    BROADCAST = 2'd2,
    INVALID   = 2'd3
  } ptype_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRC,
    ST_LEN,
    ST_PAYLOAD,
    ST_REPORT
  } state_e;

  function automatic logic [3:0] popcount(input logic [MAX_PORTS-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_PORTS; i++) n = n + 4'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/switch_pkt_classify.sv
// Combinational header classifier: packet type plus target/source/overlap rule checks.
module switch_pkt_classify
  import switch_pkt_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic [MAX_PORTS-1:0] target_i,
  input  logic [MAX_PORTS-1:0] source_i,
  output ptype_e               pkt_type_o,
  output logic                 err_source_o,
  output logic                 err_target_o,
  output logic                 err_overlap_o
);

  localparam logic [MAX_PORTS-1:0] PORT_MASK = {MAX_PORTS{1'b1}} >> (MAX_PORTS - NUM_PORTS);

  logic tgt_zero;
  logic tgt_oor;
  logic src_oor;
  logic is_bcast;

  assign tgt_zero = (target_i == '0);
  assign tgt_oor  = |(target_i & ~PORT_MASK);
  assign src_oor  = |(source_i & ~PORT_MASK);
  // Broadcast is judged on the implemented ports only; stray high bits are reported separately.
  assign is_bcast = !tgt_zero && ((target_i & PORT_MASK) == PORT_MASK);

  // NOTE: every output gets a value before any branch so no latch is inferred.
  always_comb begin
    pkt_type_o    = INVALID;
    err_target_o  = tgt_zero | tgt_oor;
    err_source_o  = (popcount(source_i) != 4'd1) | src_oor;
    err_overlap_o = !is_bcast && (|(source_i & target_i));
    if (tgt_zero)                        pkt_type_o = INVALID;
    else if (is_bcast)                   pkt_type_o = BROADCAST;
    else if (popcount(target_i) == 4'd1) pkt_type_o = SINGLE;
    else                                 pkt_type_o = MULTICAST;
  end

endmodule

// File: rtl/switch_pkt_checker.sv
// In-line packet header checker for one switch port. Statistics counters exist only
// when SWITCH_PKT_CHK_STATS_EN is defined; otherwise the counter outputs read zero.
module switch_pkt_checker
  import switch_pkt_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int MAX_LEN   = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             suspend_in,
  input  logic [7:0]       data_in,
  output logic             pkt_done,
  output logic [1:0]       pkt_type,
  output logic             err_source,
  output logic             err_target,
  output logic             err_overlap,
  output logic             err_len,
  output logic             err_frame,
  output logic [CNT_W-1:0] single_cnt,
  output logic [CNT_W-1:0] multi_cnt,
  output logic [CNT_W-1:0] bcast_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_e     state_q, state_d;
  logic [7:0] tgt_q, tgt_d;
  logic [7:0] src_q, src_d;
  logic [7:0] cnt_q, cnt_d;
  logic       len_err_q, len_err_d;

  logic accept;
  logic drop;
  logic fin;
  logic has_src;
  logic has_len;
  logic frame;

  ptype_e cls_type;
  logic   cls_err_src, cls_err_tgt, cls_ovl;
  logic   e_src, e_tgt, e_ovl, e_len, e_frm;

  assign accept = valid_in & ~suspend_in;
  assign drop   = ~valid_in & ~suspend_in;

  switch_pkt_classify #(
    .NUM_PORTS(NUM_PORTS)
  ) u_classify (
    .target_i      (tgt_q),
    .source_i      (src_q),
    .pkt_type_o    (cls_type),
    .err_source_o  (cls_err_src),
    .err_target_o  (cls_err_tgt),
    .err_overlap_o (cls_ovl)
  );

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    src_d     = src_q;
    cnt_d     = cnt_q;
    len_err_d = len_err_q;
    fin       = 1'b0;
    has_src   = 1'b1;
    has_len   = 1'b1;
    frame     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tgt_d   = data_in;
          state_d = ST_SRC;
        end
      end
      ST_SRC: begin
        if (accept) begin
          src_d   = data_in;
          state_d = ST_LEN;
        end else if (drop) begin
          has_src = 1'b0;
          has_len = 1'b0;
          frame   = 1'b1;
          fin     = 1'b1;
          state_d = ST_REPORT;
        end
      end
      ST_LEN: begin
        if (accept) begin
          len_err_d = (data_in > MAX_LEN_B);
          cnt_d     = data_in;
          if (data_in == 8'd0) begin
            fin     = 1'b1;
            state_d = ST_REPORT;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else if (drop) begin
          has_len = 1'b0;
          frame   = 1'b1;
          fin     = 1'b1;
          state_d = ST_REPORT;
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            fin     = 1'b1;
            state_d = ST_REPORT;
          end
        end else if (drop) begin
          frame   = 1'b1;
          fin     = 1'b1;
          state_d = ST_REPORT;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Checks on fields that never arrived are masked; the target is always present by now.
  assign e_src = has_src & cls_err_src;
  assign e_tgt = cls_err_tgt;
  assign e_ovl = has_src & cls_ovl;
  assign e_len = has_len & len_err_d;
  assign e_frm = frame;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      tgt_q     <= '0;
      src_q     <= '0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      src_q     <= src_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end

  logic   pkt_done_q;
  ptype_e type_q;
  logic   err_src_q, err_tgt_q, err_ovl_q, err_len_q, err_frm_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_done_q <= 1'b0;
      type_q     <= SINGLE;
      err_src_q  <= 1'b0;
      err_tgt_q  <= 1'b0;
      err_ovl_q  <= 1'b0;
      err_len_q  <= 1'b0;
      err_frm_q  <= 1'b0;
    end else begin
      pkt_done_q <= fin;
      if (fin) begin
        type_q    <= cls_type;
        err_src_q <= e_src;
        err_tgt_q <= e_tgt;
        err_ovl_q <= e_ovl;
        err_len_q <= e_len;
        err_frm_q <= e_frm;
      end
    end
  end

  assign pkt_done    = pkt_done_q;
  assign pkt_type    = type_q;
  assign err_source  = err_src_q;
  assign err_target  = err_tgt_q;
  assign err_overlap = err_ovl_q;
  assign err_len     = err_len_q;
  assign err_frame   = err_frm_q;

`ifdef SWITCH_PKT_CHK_STATS_EN
  logic [CNT_W-1:0] single_q, multi_q, bcast_q, errc_q;
  logic             any_err;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign any_err = e_src | e_tgt | e_ovl | e_len | e_frm;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      single_q <= '0;
      multi_q  <= '0;
      bcast_q  <= '0;
      errc_q   <= '0;
    end else if (fin) begin
      if (any_err) begin
        errc_q <= sat_inc(errc_q);
      end else begin
        case (cls_type)
          SINGLE:    single_q <= sat_inc(single_q);
          MULTICAST: multi_q  <= sat_inc(multi_q);
          BROADCAST: bcast_q  <= sat_inc(bcast_q);
          default:   ;
        endcase
      end
    end
  end

  assign single_cnt = single_q;
  assign multi_cnt  = multi_q;
  assign bcast_cnt  = bcast_q;
  assign err_cnt    = errc_q;
`else
  assign single_cnt = '0;
  assign multi_cnt  = '0;
  assign bcast_cnt  = '0;
  assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_switch_pkt_checker.sv
// Self-checking bench for switch_pkt_checker: directed header cases plus randomized packets,
// two instances (16-bit and 2-bit counters) compared each cycle against a packet-level model.
module tb_switch_pkt_checker;

  localparam int NP  = 4;
  localparam int ML  = 16;
  localparam int CW  = 16;
  localparam int CWB = 2;

`ifdef SWITCH_PKT_CHK_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid_in = 1'b0;
  logic       suspend_in = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic           done_a, done_b;
  logic [1:0]     type_a, type_b;
  logic           esrc_a, etgt_a, eovl_a, elen_a, efrm_a;
  logic           esrc_b, etgt_b, eovl_b, elen_b, efrm_b;
  logic [CW-1:0]  sc_a, mc_a, bc_a, ec_a;
  logic [CWB-1:0] sc_b, mc_b, bc_b, ec_b;
  logic [4:0]     errv_a, errv_b;

  assign errv_a = {efrm_a, elen_a, eovl_a, etgt_a, esrc_a};
  assign errv_b = {efrm_b, elen_b, eovl_b, etgt_b, esrc_b};

  always #5 clk = ~clk;

  switch_pkt_checker #(.NUM_PORTS(NP), .MAX_LEN(ML), .CNT_W(CW)) dut_a (
    .clk(clk), .reset(reset), .valid_in(valid_in), .suspend_in(suspend_in), .data_in(data_in),
    .pkt_done(done_a), .pkt_type(type_a), .err_source(esrc_a), .err_target(etgt_a),
    .err_overlap(eovl_a), .err_len(elen_a), .err_frame(efrm_a),
    .single_cnt(sc_a), .multi_cnt(mc_a), .bcast_cnt(bc_a), .err_cnt(ec_a)
  );

  switch_pkt_checker #(.NUM_PORTS(NP), .MAX_LEN(ML), .CNT_W(CWB)) dut_b (
    .clk(clk), .reset(reset), .valid_in(valid_in), .suspend_in(suspend_in), .data_in(data_in),
    .pkt_done(done_b), .pkt_type(type_b), .err_source(esrc_b), .err_target(etgt_b),
    .err_overlap(eovl_b), .err_len(elen_b), .err_frame(efrm_b),
    .single_cnt(sc_b), .multi_cnt(mc_b), .bcast_cnt(bc_b), .err_cnt(ec_b)
  );

  typedef struct {
    logic [7:0] tgt;
    logic [7:0] src;
    logic [7:0] len;
    int         ncap;
    bit         frame;
    bit         lit_en;
    int         l_type;
    logic [4:0] l_err;
    int         l_s, l_m, l_b, l_e, l_eb;
  } exp_t;

  exp_t       exp_map[int];
  logic [7:0] pkt_bytes[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         n_pushed = 0;
  int         n_seen = 0;
  bit         finish_req = 1'b0;
  bit         report_next = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v, input int w);
    return (v == (1 << w) - 1) ? v : v + 1;
  endfunction

  // Packet-level rules: type from the target, checks only on the fields that arrived.
  function automatic void model_eval(input exp_t r, output int ty, output logic [4:0] e);
    int  mask, t, s;
    bit  has_s, has_l;
    mask  = (1 << NP) - 1;
    t     = int'(r.tgt);
    s     = int'(r.src);
    has_s = (r.ncap >= 2);
    has_l = (r.ncap >= 3);
    if (t == 0)                  ty = 3;
    else if ((t & mask) == mask) ty = 2;
    else if ($countones(t) == 1) ty = 0;
    else                         ty = 1;
    e[0] = has_s && (($countones(s) != 1) || ((s & ~mask) != 0));
    e[1] = (t == 0) || ((t & ~mask) != 0);
    e[2] = has_s && (ty != 2) && ((s & t) != 0);
    e[3] = has_l && (int'(r.len) > ML);
    e[4] = r.frame;
  endfunction

  int         m_type = 0;
  logic [4:0] m_err = '0;
  int         ma[4] = '{0, 0, 0, 0};
  int         mb[4] = '{0, 0, 0, 0};

  always @(negedge clk) begin
    exp_t       r;
    int         ty, idx;
    logic [4:0] e;
    bit         exp_done;
    exp_done = reset && exp_map.exists(cyc);
    if (!reset) begin
      m_type = 0;
      m_err  = '0;
      for (int i = 0; i < 4; i++) begin
        ma[i] = 0;
        mb[i] = 0;
      end
    end else if (exp_done) begin
      r = exp_map[cyc];
      model_eval(r, ty, e);
      m_type = ty;
      m_err  = e;
      if (STATS_EN) begin
        idx    = (e != 0) ? 3 : ty;
        ma[idx] = sat(ma[idx], CW);
        mb[idx] = sat(mb[idx], CWB);
      end
      n_seen++;
      if (r.lit_en) begin
        if (r.l_type >= 0) check("lit_type", 32'(type_a), r.l_type);
        check("lit_err", 32'(errv_a), 32'(r.l_err));
        check("lit_single", 32'(sc_a), STATS_EN ? r.l_s : 0);
        check("lit_multi", 32'(mc_a), STATS_EN ? r.l_m : 0);
        check("lit_bcast", 32'(bc_a), STATS_EN ? r.l_b : 0);
        check("lit_errcnt", 32'(ec_a), STATS_EN ? r.l_e : 0);
        check("lit_errcnt_sat", 32'(ec_b), STATS_EN ? r.l_eb : 0);
      end
    end
    check("pkt_done_a", 32'(done_a), 32'(exp_done));
    check("pkt_done_b", 32'(done_b), 32'(exp_done));
    check("pkt_type_a", 32'(type_a), m_type);
    check("pkt_type_b", 32'(type_b), m_type);
    check("err_flags_a", 32'(errv_a), 32'(m_err));
    check("err_flags_b", 32'(errv_b), 32'(m_err));
    check("single_cnt_a", 32'(sc_a), ma[0]);
    check("multi_cnt_a", 32'(mc_a), ma[1]);
    check("bcast_cnt_a", 32'(bc_a), ma[2]);
    check("err_cnt_a", 32'(ec_a), ma[3]);
    check("single_cnt_b", 32'(sc_b), mb[0]);
    check("multi_cnt_b", 32'(mc_b), mb[1]);
    check("bcast_cnt_b", 32'(bc_b), mb[2]);
    check("err_cnt_b", 32'(ec_b), mb[3]);
    if (finish_req) begin
      check("all_packets_reported", n_seen, n_pushed);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    valid_in   = v;
    suspend_in = s;
    data_in    = d;
    @(posedge clk);
    #1;
  endtask

  // The cycle after a finished packet is REPORT: optionally offer byte0 there, which must be ignored.
  task automatic lead_in(input logic [7:0] b0, input int max_gap);
    if (report_next) begin
      if ($urandom_range(0, 1) == 1) drive(1'b1, 1'b0, b0);
      else                           drive(1'b0, 1'($urandom_range(0, 1)), 8'h00);
      report_next = 1'b0;
    end
    repeat ($urandom_range(0, max_gap)) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_pkt(input int stall_pct, input int frame_k, input int stall_at,
                          input int stall_n, input bit lit_en, input int l_type,
                          input logic [4:0] l_err, input int l_s, input int l_m,
                          input int l_b, input int l_e, input int l_eb);
    exp_t r;
    int   n;
    n        = pkt_bytes.size();
    r.tgt    = pkt_bytes[0];
    r.src    = (n > 1) ? pkt_bytes[1] : 8'h00;
    r.len    = (n > 2) ? pkt_bytes[2] : 8'h00;
    r.lit_en = lit_en;
    r.l_type = l_type;
    r.l_err  = l_err;
    r.l_s    = l_s;
    r.l_m    = l_m;
    r.l_b    = l_b;
    r.l_e    = l_e;
    r.l_eb   = l_eb;
    lead_in(pkt_bytes[0], 2);
    for (int k = 0; k < n; k++) begin
      if (k == stall_at) repeat (stall_n) drive(1'($urandom_range(0, 1)), 1'b1, 8'($urandom));
      for (int s = 0; s < 3 && $urandom_range(0, 99) < stall_pct; s++)
        drive(1'($urandom_range(0, 1)), 1'b1, 8'($urandom));
      if (k == frame_k) begin
        r.ncap  = k;
        r.frame = 1'b1;
        exp_map[cyc + 1] = r;
        n_pushed++;
        drive(1'b0, 1'b0, 8'($urandom));
        report_next = 1'b1;
        return;
      end
      if (k == n - 1) begin
        r.ncap  = 3;
        r.frame = 1'b0;
        exp_map[cyc + 1] = r;
        n_pushed++;
      end
      drive(1'b1, 1'b0, pkt_bytes[k]);
    end
    report_next = 1'b1;
  endtask

  initial begin
    int rr;
    logic [7:0] tgt, src, len;
    int frame_k;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00);

    pkt_bytes = '{8'h04, 8'h01, 8'h02, 8'hAA, 8'hBB};
    send_pkt(0, -1, -1, 0, 1'b1, 0, 5'b00000, 1, 0, 0, 0, 0);
    pkt_bytes = '{8'h0F, 8'h02, 8'h00};
    send_pkt(0, -1, -1, 0, 1'b1, 2, 5'b00000, 1, 0, 1, 0, 0);
    pkt_bytes = '{8'h06, 8'h02, 8'h01, 8'h55};
    send_pkt(0, -1, -1, 0, 1'b1, 1, 5'b00100, 1, 0, 1, 1, 1);
    pkt_bytes = '{8'h10, 8'h03, 8'h00};
    send_pkt(0, -1, -1, 0, 1'b1, -1, 5'b00011, 1, 0, 1, 2, 2);
    pkt_bytes = '{8'h01, 8'h02, 8'd20};
    for (int i = 0; i < 20; i++) pkt_bytes.push_back(8'(i + 1));
    send_pkt(0, -1, -1, 0, 1'b1, 0, 5'b01000, 1, 0, 1, 3, 3);
    pkt_bytes = '{8'h02, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33};
    send_pkt(0, -1, 4, 3, 1'b1, 0, 5'b00000, 2, 0, 1, 3, 3);
    pkt_bytes = '{8'h01, 8'h02, 8'h00};
    send_pkt(0, 2, -1, 0, 1'b1, 0, 5'b10000, 2, 0, 1, 4, 3);

    // Reset in the middle of a payload: packet vanishes and counters clear.
    lead_in(8'h01, 1);
    drive(1'b1, 1'b0, 8'h01);
    drive(1'b1, 1'b0, 8'h02);
    drive(1'b1, 1'b0, 8'h05);
    drive(1'b1, 1'b0, 8'hAA);
    drive(1'b1, 1'b0, 8'hBB);
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    reset = 1'b1;
    report_next = 1'b0;

    pkt_bytes = '{8'h08, 8'h01, 8'h00};
    send_pkt(0, -1, -1, 0, 1'b1, 0, 5'b00000, 1, 0, 0, 0, 0);

    for (int p = 0; p < 300; p++) begin
      rr = $urandom_range(0, 99);
      if (rr < 65)      tgt = 8'($urandom_range(1, 15));
      else if (rr < 75) tgt = 8'h00;
      else if (rr < 85) tgt = 8'h0F;
      else              tgt = 8'($urandom);
      rr = $urandom_range(0, 99);
      if (rr < 75)      src = 8'(1 << $urandom_range(0, NP - 1));
      else if (rr < 85) src = 8'h00;
      else              src = 8'($urandom);
      rr = $urandom_range(0, 99);
      if (rr < 80)      len = 8'($urandom_range(0, ML));
      else if (rr < 97) len = 8'($urandom_range(ML + 1, 40));
      else              len = 8'($urandom_range(200, 255));
      pkt_bytes.delete();
      pkt_bytes.push_back(tgt);
      pkt_bytes.push_back(src);
      pkt_bytes.push_back(len);
      for (int i = 0; i < int'(len); i++) pkt_bytes.push_back(8'($urandom));
      frame_k = ($urandom_range(0, 99) < 10) ? $urandom_range(1, pkt_bytes.size() - 1) : -1;
      send_pkt(25, frame_k, -1, 0, 1'b0, -1, 5'b00000, 0, 0, 0, 0, 0);
    end

    repeat (4) drive(1'b0, 1'b0, 8'h00);
    finish_req = 1'b1;
    repeat (20) drive(1'b0, 1'b0, 8'h00);
    $display("FAIL watchdog: got no summary, expected one within 20 cycles");
    $fatal(1, "bench watchdog expired");
  end

endmodule
